if_fetch_unit: RTL and testbench

- Instruction-fetch stage of the pipelined LC-3b core; sits directly upstream of the IF/ID pipeline latch.
- Owns the PC and drives the instruction-memory read handshake.
- Absorbs downstream stalls with a one-entry hold buffer and handles branch/jump redirects from later stages, including redirects that arrive while a memory read is outstanding.
- Each cycle it presents pc+2, the instruction, a valid bit and a load strobe to the IF/ID latch.

---
 rtl/if_fetch_unit_pkg.sv | 19 +
 rtl/if_fetch_unit_if.sv | 23 ++
 rtl/if_fetch_unit.sv | 120 ++++++++++++
 tb/tb_if_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - LC-3b fetch-stage types and constants
package if_fetch_unit_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam lc3b_word LC3B_NOP     = 16'h0000;
    localparam lc3b_word LC3B_PC_STEP = 16'd2;

    function automatic lc3b_word pc_next(input lc3b_word pc);
        return pc + LC3B_PC_STEP;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction-memory read handshake bundle
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic     imem_read;
    logic     imem_resp;
    lc3b_word imem_address;
    lc3b_word imem_rdata;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_resp,
        input  imem_rdata
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_resp,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - LC-3b instruction fetch with one-entry hold buffer and redirect drain
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic                   clk,
    input  logic                   reset,
    if_fetch_unit_if.master        imem,
    input  logic                   stall_i,
    input  logic                   redirect_valid_i,
    input  lc3b_word               redirect_pc_i,
    output logic                   ifid_load_o,
    output lc3b_word               pc_out_o,
    output lc3b_word               instruction_out_o,
    output logic                   valid_out_o
);

    fetch_state_t state_q, state_d;
    lc3b_word     pc_q, pc_d;
    lc3b_word     pending_pc_q, pending_pc_d;
    lc3b_word     buf_instr_q, buf_instr_d;
    lc3b_word     buf_pc_q, buf_pc_d;

    logic         read_c;
    logic         valid_c;
    lc3b_word     instr_c;
    lc3b_word     pc_out_c;
    lc3b_word     pc_inc;

    assign pc_inc = pc_next(pc_q);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;
        read_c       = 1'b0;
        valid_c      = 1'b0;
        instr_c      = LC3B_NOP;
        pc_out_c     = 16'h0000;

        unique case (state_q)
            FETCH: begin
                read_c = 1'b1;
                if (redirect_valid_i) begin
                    // Without a response the read is still in flight; wait it out in DRAIN.
                    if (imem.imem_resp) begin
                        pc_d = redirect_pc_i;
                    end else begin
                        pending_pc_d = redirect_pc_i;
                        state_d      = DRAIN;
                    end
                end else if (imem.imem_resp) begin
                    pc_d = pc_inc;
                    if (!stall_i) begin
                        valid_c  = 1'b1;
                        instr_c  = imem.imem_rdata;
                        pc_out_c = pc_inc;
                    end else begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc_d    = pc_inc;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    valid_c  = 1'b1;
                    instr_c  = buf_instr_q;
                    pc_out_c = buf_pc_q;
                    state_d  = FETCH;
                end
            end
            DRAIN: begin
                read_c = 1'b1;
                if (redirect_valid_i) begin
                    pending_pc_d = redirect_pc_i;
                end
                if (imem.imem_resp) begin
                    pc_d    = redirect_valid_i ? redirect_pc_i : pending_pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        imem.imem_read    = read_c && !reset;
        imem.imem_address = pc_q;
        ifid_load_o       = (!stall_i || redirect_valid_i) && !reset;
        valid_out_o       = valid_c && !reset;
        instruction_out_o = reset ? LC3B_NOP : instr_c;
        pc_out_o          = reset ? 16'h0000 : pc_out_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pending_pc_q <= 16'h0000;
            buf_instr_q  <= 16'h0000;
            buf_pc_q     <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit with queue-based reference model
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    logic     stall;
    logic     redir;
    lc3b_word redir_pc;
    logic     ifid_load;
    lc3b_word pc_out;
    lc3b_word instr_out;
    logic     valid_out;

    int total = 0;
    int bad   = 0;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem              (imem_bus),
        .stall_i           (stall),
        .redirect_valid_i  (redir),
        .redirect_pc_i     (redir_pc),
        .ifid_load_o       (ifid_load),
        .pc_out_o          (pc_out),
        .instruction_out_o (instr_out),
        .valid_out_o       (valid_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: next address to fetch, a queue of held deliveries, and an optional drain target.
    typedef struct packed { lc3b_word instr; lc3b_word pc; } held_t;
    held_t    held[$];
    lc3b_word m_pc     = 16'h0000;
    logic     m_drain  = 1'b0;
    lc3b_word m_target = 16'h0000;

    always @(negedge clk) begin
        logic     e_valid;
        logic     e_known;
        lc3b_word e_instr, e_pcout, nxt;
        e_valid = 1'b0; e_known = 1'b1; e_instr = LC3B_NOP; e_pcout = 16'h0000;
        if (reset) begin
            chk("m_rst_read", {15'd0, imem_bus.imem_read}, 16'd0);
            chk("m_rst_load", {15'd0, ifid_load}, 16'd0);
            chk("m_rst_valid", {15'd0, valid_out}, 16'd0);
            chk("m_rst_pcout", pc_out, 16'h0000);
            chk("m_rst_instr", instr_out, 16'h0000);
            held.delete();
            m_pc = 16'h0000; m_drain = 1'b0;
        end else begin
            chk("m_read", {15'd0, imem_bus.imem_read}, {15'd0, held.size() == 0});
            if (held.size() == 0) chk("m_addr", imem_bus.imem_address, m_pc);
            chk("m_load", {15'd0, ifid_load}, {15'd0, !stall || redir});
            if (held.size() != 0) begin
                if (redir) begin
                    held.delete(); m_pc = redir_pc;
                end else if (!stall) begin
                    e_valid = 1'b1; e_instr = held[0].instr; e_pcout = held[0].pc;
                    held.delete();
                end else begin
                    e_known = 1'b0;
                end
            end else if (m_drain) begin
                if (imem_bus.imem_resp) begin
                    m_pc = redir ? redir_pc : m_target; m_drain = 1'b0;
                end else if (redir) begin
                    m_target = redir_pc;
                end
            end else if (redir) begin
                if (imem_bus.imem_resp) m_pc = redir_pc;
                else begin m_drain = 1'b1; m_target = redir_pc; end
            end else if (imem_bus.imem_resp) begin
                nxt = m_pc + 16'd2;
                if (!stall) begin
                    e_valid = 1'b1; e_instr = imem_bus.imem_rdata; e_pcout = nxt;
                end else begin
                    held.push_back('{instr: imem_bus.imem_rdata, pc: nxt});
                end
                m_pc = nxt;
            end
            if (e_known) begin
                chk("m_valid", {15'd0, valid_out}, {15'd0, e_valid});
                chk("m_instr", instr_out, e_instr);
                if (e_valid) chk("m_pcout", pc_out, e_pcout);
            end
        end
    end

    // Drive one cycle of inputs, then return at negedge+1 so the caller can check.
    task automatic step(input logic rs, input logic rp, input lc3b_word rd,
                        input logic st, input logic rv, input lc3b_word rpc);
        @(posedge clk); #1;
        reset = rs; imem_bus.imem_resp = rp; imem_bus.imem_rdata = rd;
        stall = st; redir = rv; redir_pc = rpc;
        @(negedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = 16'h0000;
        imem_bus.imem_resp = 1'b0; imem_bus.imem_rdata = 16'h0000;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_read", {15'd0, imem_bus.imem_read}, 16'd0);
        chk("rst_load", {15'd0, ifid_load}, 16'd0);

        // zero-wait fetches
        step(0, 1, 16'h1234, 0, 0, 0);
        chk("t1_addr0", imem_bus.imem_address, 16'h0000);
        chk("t1_pc0", pc_out, 16'h0002);
        chk("t1_ins0", instr_out, 16'h1234);
        chk("t1_load0", {15'd0, ifid_load}, 16'd1);
        step(0, 1, 16'h5678, 0, 0, 0);
        chk("t1_addr1", imem_bus.imem_address, 16'h0002);
        chk("t1_pc1", pc_out, 16'h0004);
        chk("t1_val1", {15'd0, valid_out}, 16'd1);
        for (int i = 0; i < 6; i++) step(0, 1, 16'h0100 + 16'(i), 0, 0, 0);

        // stall on the response of 0x0010
        step(0, 1, 16'hABCD, 1, 0, 0);
        chk("t2_addr", imem_bus.imem_address, 16'h0010);
        chk("t2_load_s0", {15'd0, ifid_load}, 16'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("t2_read_s1", {15'd0, imem_bus.imem_read}, 16'd0);
        chk("t2_load_s1", {15'd0, ifid_load}, 16'd0);
        step(0, 0, 0, 1, 0, 0);
        chk("t2_read_s2", {15'd0, imem_bus.imem_read}, 16'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("t2_val", {15'd0, valid_out}, 16'd1);
        chk("t2_ins", instr_out, 16'hABCD);
        chk("t2_pc", pc_out, 16'h0012);
        step(0, 1, 16'h2000, 0, 0, 0);
        chk("t2_next", imem_bus.imem_address, 16'h0012);
        for (int i = 0; i < 6; i++) step(0, 1, 16'h2001 + 16'(i), 0, 0, 0);

        // redirect while 0x0020 is outstanding
        step(0, 0, 0, 0, 1, 16'h0400);
        chk("t3_addr_r", imem_bus.imem_address, 16'h0020);
        chk("t3_load_r", {15'd0, ifid_load}, 16'd1);
        chk("t3_val_r", {15'd0, valid_out}, 16'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_addr_w", imem_bus.imem_address, 16'h0020);
        step(0, 1, 16'hDEAD, 0, 0, 0);
        chk("t3_val_d", {15'd0, valid_out}, 16'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("t3_next", imem_bus.imem_address, 16'h0400);

        // redirect out of HOLD
        step(0, 1, 16'h1111, 1, 0, 0);
        step(0, 0, 0, 1, 1, 16'h0100);
        chk("t4_load", {15'd0, ifid_load}, 16'd1);
        chk("t4_val", {15'd0, valid_out}, 16'd0);
        chk("t4_nop", instr_out, 16'h0000);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_next", imem_bus.imem_address, 16'h0100);

        // wrap at 0xFFFE
        step(0, 1, 16'h3333, 0, 1, 16'hFFFE);
        step(0, 1, 16'h7777, 0, 0, 0);
        chk("t5_addr", imem_bus.imem_address, 16'hFFFE);
        chk("t5_pc", pc_out, 16'h0000);
        step(0, 0, 0, 0, 0, 0);
        chk("t5_next", imem_bus.imem_address, 16'h0000);

        // reset mid-read at 0x0030, with a late response during reset
        step(0, 1, 16'h4444, 0, 1, 16'h0030);
        step(0, 0, 0, 0, 0, 0);
        chk("t6_addr", imem_bus.imem_address, 16'h0030);
        step(1, 0, 0, 0, 0, 0);
        chk("t6_read", {15'd0, imem_bus.imem_read}, 16'd0);
        chk("t6_load", {15'd0, ifid_load}, 16'd0);
        step(1, 1, 16'h5555, 0, 0, 0);
        chk("t6_late", {15'd0, valid_out}, 16'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("t6_first", imem_bus.imem_address, 16'h0000);
        chk("t6_rd1", {15'd0, imem_bus.imem_read}, 16'd1);
        step(0, 1, 16'h4242, 0, 0, 0);
        chk("t6_pc", pc_out, 16'h0002);
        chk("t6_ins", instr_out, 16'h4242);

        step(0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
